// File: rtl/reg_file_mp.sv
// reg_file_mp: NRD-port registered-read register file with busy scoreboard.
// Define REG_FILE_BYPASS_EN for same-edge write/alloc-to-read forwarding.
module reg_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]    rs_busy,
  input  logic              we,
  input  logic [AW-1:0]     rd,
  input  logic [XLEN-1:0]   rd_v,
  input  logic              alloc,
  input  logic [AW-1:0]     alloc_rd,
  output logic [AW:0]       busy_cnt
);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    busy;
  logic [NREGS-1:0]    busy_nxt;
  logic                wr_hit;
  logic                al_hit;
  logic                cnt_inc;
  logic                cnt_dec;
  logic [NRD*XLEN-1:0] rdat_nxt;
  logic [NRD-1:0]      rbsy_nxt;

  // alloc is applied after the write so it wins on a collision
  always_comb begin
    wr_hit   = we && (rd != '0);
    al_hit   = alloc && (alloc_rd != '0);
    busy_nxt = busy;
    if (wr_hit)
      busy_nxt[rd] = 1'b0;
    if (al_hit)
      busy_nxt[alloc_rd] = 1'b1;
    cnt_inc = al_hit && !busy[alloc_rd];
    cnt_dec = wr_hit && busy[rd] &&
              !(al_hit && (alloc_rd == rd));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_hit)
        regs[rd] <= rd_v;
      busy <= busy_nxt;
      unique case ({cnt_inc, cnt_dec})
        2'b10:   busy_cnt <= busy_cnt + 1'b1;
        2'b01:   busy_cnt <= busy_cnt - 1'b1;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] d;
    logic            b;

    assign ra = rs_addr[g*AW +: AW];

    always_comb begin
      d = regs[ra];
      b = busy[ra];
`ifdef REG_FILE_BYPASS_EN
      if (wr_hit && (rd == ra))
        d = rd_v;
      b = busy_nxt[ra];
`endif
      if (ra == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rdat_nxt[g*XLEN +: XLEN] = d;
    assign rbsy_nxt[g]              = b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data <= '0;
      rs_busy <= '0;
    end else begin
      rs_data <= rdat_nxt;
      rs_busy <= rbsy_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: vector table + scoreboard bench for reg_file_mp.
// Second instance covers the 4-port / 16-reg / 16-bit configuration.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] rd_v;
  logic        alloc;
  logic [4:0]  alloc_rd;
  logic [5:0]  busy_cnt;

  logic [15:0] q_addr;
  logic [63:0] q_data;
  logic [3:0]  q_busy;
  logic        q_we;
  logic [3:0]  q_rd;
  logic [15:0] q_rd_v;
  logic        q_alloc;
  logic [3:0]  q_alloc_rd;
  logic [4:0]  q_cnt;

  reg_file_mp dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .we(we), .rd(rd), .rd_v(rd_v),
    .alloc(alloc), .alloc_rd(alloc_rd),
    .busy_cnt(busy_cnt)
  );

  reg_file_mp #(.XLEN(16), .NREGS(16), .NRD(4)) dut4 (
    .clk(clk), .rst(rst),
    .rs_addr(q_addr), .rs_data(q_data), .rs_busy(q_busy),
    .we(q_we), .rd(q_rd), .rd_v(q_rd_v),
    .alloc(q_alloc), .alloc_rd(q_alloc_rd),
    .busy_cnt(q_cnt)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rd_v;
    logic        al;
    logic [4:0]  al_rd;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [5:0]  cnt;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [5:0]  cnt;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we_i, input logic [4:0] rd_i, input logic [31:0] v_i,
    input logic al_i, input logic [4:0] ar_i,
    input logic [4:0] a0_i, input logic [4:0] a1_i,
    input logic [31:0] d0_i, input logic [31:0] d1_i,
    input logic b0_i, input logic b1_i, input logic [5:0] c_i);
    vec_t v;
    v.we = we_i; v.rd = rd_i; v.rd_v = v_i;
    v.al = al_i; v.al_rd = ar_i;
    v.a0 = a0_i; v.a1 = a1_i;
    v.d0 = d0_i; v.d1 = d1_i;
    v.b0 = b0_i; v.b1 = b1_i; v.cnt = c_i;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    we       = v.we;
    rd       = v.rd;
    rd_v     = v.rd_v;
    alloc    = v.al;
    alloc_rd = v.al_rd;
    rs_addr  = {v.a1, v.a0};
    e.d0 = v.d0; e.d1 = v.d1;
    e.b0 = v.b0; e.b1 = v.b1;
    e.cnt = v.cnt; e.id = id;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    we    = 1'b0;
    alloc = 1'b0;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty v%0d got 0 want 1", id);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("v%0d d0", e.id), 64'(rs_data[31:0]), 64'(e.d0));
      chk($sformatf("v%0d d1", e.id), 64'(rs_data[63:32]), 64'(e.d1));
      chk($sformatf("v%0d b0", e.id), 64'(rs_busy[0]), 64'(e.b0));
      chk($sformatf("v%0d b1", e.id), 64'(rs_busy[1]), 64'(e.b1));
      chk($sformatf("v%0d cnt", e.id), 64'(busy_cnt), 64'(e.cnt));
    end
  endtask

  task automatic q_write(input logic [3:0] r, input logic [15:0] v);
    q_we   = 1'b1;
    q_rd   = r;
    q_rd_v = v;
    @(posedge clk);
    #1;
    q_we = 1'b0;
  endtask

  vec_t tbl[15];
  localparam logic [31:0] Z = 32'h0;

  initial begin
    rst = 1'b1;
    rs_addr = '0; we = 1'b0; rd = '0; rd_v = '0;
    alloc = 1'b0; alloc_rd = '0;
    q_addr = '0; q_we = 1'b0; q_rd = '0; q_rd_v = '0;
    q_alloc = 1'b0; q_alloc_rd = '0;

    //          we    rd     rd_v          al    ar     a0     a1     d0            d1            b0    b1    cnt
    tbl[0]  = mk(1'b1,5'd0, 32'hFFFFFFFF,1'b1,5'd0, 5'd0, 5'd0, Z,           Z,            1'b0,1'b0,6'd0);
    tbl[1]  = mk(1'b0,5'd0, Z,           1'b0,5'd0, 5'd0, 5'd0, Z,           Z,            1'b0,1'b0,6'd0);
    tbl[2]  = mk(1'b0,5'd0, Z,           1'b1,5'd3, 5'd0, 5'd0, Z,           Z,            1'b0,1'b0,6'd1);
    tbl[3]  = mk(1'b0,5'd0, Z,           1'b1,5'd7, 5'd3, 5'd0, Z,           Z,            1'b1,1'b0,6'd2);
    tbl[4]  = mk(1'b1,5'd3, 32'h1234,    1'b0,5'd0, 5'd7, 5'd0, Z,           Z,            1'b1,1'b0,6'd1);
    tbl[5]  = mk(1'b0,5'd0, Z,           1'b0,5'd0, 5'd3, 5'd7, 32'h1234,    Z,            1'b0,1'b1,6'd1);
    tbl[6]  = mk(1'b0,5'd0, Z,           1'b1,5'd9, 5'd7, 5'd3, Z,           32'h1234,     1'b1,1'b0,6'd2);
    tbl[7]  = mk(1'b1,5'd9, 32'hAA,      1'b1,5'd9, 5'd3, 5'd7, 32'h1234,    Z,            1'b0,1'b1,6'd2);
    tbl[8]  = mk(1'b0,5'd0, Z,           1'b0,5'd0, 5'd9, 5'd9, 32'hAA,      32'hAA,       1'b1,1'b1,6'd2);
    tbl[9]  = mk(1'b0,5'd0, Z,           1'b1,5'd7, 5'd9, 5'd0, 32'hAA,      Z,            1'b1,1'b0,6'd2);
    tbl[10] = mk(1'b1,5'd7, 32'h77,      1'b1,5'd10,5'd9, 5'd3, 32'hAA,      32'h1234,     1'b1,1'b0,6'd2);
    tbl[11] = mk(1'b0,5'd0, Z,           1'b0,5'd0, 5'd7, 5'd10,32'h77,      Z,            1'b0,1'b1,6'd2);
    tbl[12] = mk(1'b1,5'd20,32'h20,      1'b0,5'd0, 5'd0, 5'd9, Z,           32'hAA,       1'b0,1'b1,6'd2);
    tbl[13] = mk(1'b1,5'd9, 32'hBB,      1'b0,5'd0, 5'd20,5'd10,32'h20,      Z,            1'b0,1'b1,6'd1);
    tbl[14] = mk(1'b1,5'd10,32'h10,      1'b0,5'd0, 5'd9, 5'd20,32'hBB,      32'h20,       1'b0,1'b0,6'd0);

    #12;
    chk("rst data", rs_data, 64'h0);
    chk("rst busy", 64'(rs_busy), 64'h0);
    chk("rst cnt", 64'(busy_cnt), 64'h0);
    chk("rst q_cnt", 64'(q_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++)
      apply(tbl[i], i);

    apply(mk(1'b1,5'd4,32'h11,1'b0,5'd0,5'd0,5'd0,Z,Z,1'b0,1'b0,6'd0), 100);
`ifdef REG_FILE_BYPASS_EN
    apply(mk(1'b1,5'd4,32'h55,1'b0,5'd0,5'd4,5'd4,32'h55,32'h55,1'b0,1'b0,6'd0), 101);
`else
    apply(mk(1'b1,5'd4,32'h55,1'b0,5'd0,5'd4,5'd4,32'h11,32'h11,1'b0,1'b0,6'd0), 101);
`endif
    apply(mk(1'b0,5'd0,Z,1'b0,5'd0,5'd4,5'd0,32'h55,Z,1'b0,1'b0,6'd0), 102);
`ifdef REG_FILE_BYPASS_EN
    apply(mk(1'b1,5'd4,32'h66,1'b1,5'd4,5'd4,5'd4,32'h66,32'h66,1'b1,1'b1,6'd1), 103);
`else
    apply(mk(1'b1,5'd4,32'h66,1'b1,5'd4,5'd4,5'd4,32'h55,32'h55,1'b0,1'b0,6'd1), 103);
`endif
    apply(mk(1'b0,5'd0,Z,1'b0,5'd0,5'd4,5'd4,32'h66,32'h66,1'b1,1'b1,6'd1), 104);

    apply(mk(1'b1,5'd5,32'hDEADBEEF,1'b1,5'd6,5'd4,5'd0,32'h66,Z,1'b1,1'b0,6'd2), 105);
    apply(mk(1'b0,5'd0,Z,1'b0,5'd0,5'd5,5'd6,32'hDEADBEEF,Z,1'b0,1'b1,6'd2), 106);
    #3;
    rst = 1'b1;
    #1;
    chk("async data", rs_data, 64'h0);
    chk("async busy", 64'(rs_busy), 64'h0);
    chk("async cnt", 64'(busy_cnt), 64'h0);
    #2;
    rst = 1'b0;
    apply(mk(1'b0,5'd0,Z,1'b0,5'd0,5'd5,5'd6,Z,Z,1'b0,1'b0,6'd0), 107);

    q_write(4'd1, 16'h1111);
    q_write(4'd2, 16'h2222);
    q_write(4'd15, 16'hF00F);
    q_addr = {4'd15, 4'd1, 4'd2, 4'd1};
    @(posedge clk);
    #1;
    chk("q p0", 64'(q_data[15:0]), 64'h1111);
    chk("q p1", 64'(q_data[31:16]), 64'h2222);
    chk("q p2", 64'(q_data[47:32]), 64'h1111);
    chk("q p3", 64'(q_data[63:48]), 64'hF00F);
    chk("q busy", 64'(q_busy), 64'h0);
    q_alloc    = 1'b1;
    q_alloc_rd = 4'd15;
    @(posedge clk);
    #1;
    q_alloc = 1'b0;
    @(posedge clk);
    #1;
    chk("q busy15", 64'(q_busy), 64'h8);
    chk("q cnt", 64'(q_cnt), 64'h1);

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover got %0d want 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
